// File: rtl/rd_add_man_pkg.sv
// Shared widths, state encoding and address/length helpers for the line-buffer read address manager.
// The width macros normally come from the shared mydefines.v; they are only defined here if absent.
`ifndef IMGT_WIDTH
`define IMGT_WIDTH 10
`endif
`ifndef IMGS_HEIGHT
`define IMGS_HEIGHT 9
`endif
`ifndef BURST_LENGTH
`define BURST_LENGTH 9
`endif
`ifndef BURST_ADD_LENGTH
`define BURST_ADD_LENGTH 22
`endif

package rd_add_man_pkg;

  localparam int IMGT_W = `IMGT_WIDTH;
  localparam int IMGS_H = `IMGS_HEIGHT;
  localparam int LINE_W = `IMGS_HEIGHT + 1;
  localparam int BLEN_W = `BURST_LENGTH;
  localparam int BADD_W = `BURST_ADD_LENGTH;

  typedef enum logic [3:0] {
    IDLE       = 4'h1,
    BURST_REQ  = 4'h2,
    BURST_DATA = 4'h4,
    LINE_DONE  = 4'h8
  } state_t;

  // Full 256-word segments plus one partial segment for any remainder.
  function automatic logic [2:0] seg_count(input logic [IMGT_W-1:0] tw);
    return {1'b0, tw[9:8]} + {2'b00, (tw[7:0] != 8'h00)};
  endfunction

  function automatic logic [BLEN_W-1:0] seg_len(input logic [IMGT_W-1:0] tw,
                                                input logic [1:0] s);
    if (({1'b0, s} == seg_count(tw) - 3'd1) && (tw[7:0] != 8'h00))
      return {1'b0, tw[7:0]};
    return 9'h100;
  endfunction

  function automatic logic [BADD_W-1:0] burst_addr(input logic bank,
                                                   input logic [LINE_W-1:0] line,
                                                   input logic [1:0] s);
    return {1'b0, bank, line[0], line[IMGS_H:1], s, 8'h00};
  endfunction

endpackage

// File: rtl/rd_add_man_edge_sync.sv
// Two-flop synchroniser for an asynchronous level, followed by a one-cycle rising-edge pulse.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [2:0] sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh <= 3'b000;
    else     sh <= {sh[1:0], d};
  end

  assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/rd_add_man.sv
// Read address manager: splits each output line into SDRAM read bursts and
// addresses the line buffer; frame restarts are deferred until the FSM is idle.
module rd_add_man
  import rd_add_man_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              line_req,
  output logic              line_ack,
  output logic              line_done,
  output logic              data_wen,
  output logic [IMGT_W-1:0] data_address,
  output logic              burst_req,
  output logic [BLEN_W-1:0] burst_length,
  output logic [BADD_W-1:0] burst_address,
  input  logic              burst_ack,
  input  logic              burst_holda,
  input  logic [1:0]        wr_pic_number,
  output logic [1:0]        rd_pic_number,
  input  logic [IMGT_W-1:0] target_width,
  input  logic [IMGS_H:0]   target_height
);

  state_t            state;
  logic              fs_rise;
  logic              pending;
  logic              rd_bank;
  logic [LINE_W-1:0] out_line;
  logic [1:0]        seg;
  logic [BLEN_W-1:0] word;
  logic [BLEN_W-1:0] word_nxt;
  logic [2:0]        n_seg;
  logic              unused_wr_lsb;

  edge_sync u_fs_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (frame_start),
    .rise (fs_rise)
  );

  assign n_seg         = seg_count(target_width);
  assign word_nxt      = word + BLEN_W'(1);
  assign data_wen      = burst_holda;
  assign rd_pic_number = {rd_bank, out_line[0]};
  assign unused_wr_lsb = wr_pic_number[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      line_ack      <= 1'b0;
      line_done     <= 1'b0;
      burst_req     <= 1'b0;
      burst_length  <= 9'h100;
      burst_address <= '0;
      out_line      <= '0;
      rd_bank       <= 1'b0;
      seg           <= 2'd0;
      word          <= '0;
      data_address  <= '0;
      pending       <= 1'b0;
    end else begin
      line_ack  <= 1'b0;
      line_done <= 1'b0;
      if (fs_rise && (state != IDLE)) pending <= 1'b1;

      case (state)
        IDLE: begin
          // A restart always wins over a simultaneous line request.
          if (fs_rise || pending) begin
            pending  <= 1'b0;
            out_line <= '0;
            rd_bank  <= ~wr_pic_number[1];
          end else if (line_req) begin
            line_ack     <= 1'b1;
            seg          <= 2'd0;
            data_address <= '0;
            if ((out_line < target_height) && (n_seg != 3'd0)) begin
              state         <= BURST_REQ;
              burst_req     <= 1'b1;
              burst_length  <= seg_len(target_width, 2'd0);
              burst_address <= burst_addr(rd_bank, out_line, 2'd0);
            end else begin
              state <= LINE_DONE;
            end
          end
        end

        BURST_REQ: begin
          if (burst_ack) begin
            state     <= BURST_DATA;
            burst_req <= 1'b0;
            word      <= '0;
          end
        end

        BURST_DATA: begin
          if (burst_holda) begin
            word         <= word_nxt;
            data_address <= data_address + IMGT_W'(1);
            if (word_nxt == burst_length) begin
              if ({1'b0, seg} == n_seg - 3'd1) begin
                state <= LINE_DONE;
              end else begin
                seg           <= seg + 2'd1;
                state         <= BURST_REQ;
                burst_req     <= 1'b1;
                burst_length  <= seg_len(target_width, seg + 2'd1);
                burst_address <= burst_addr(rd_bank, out_line, seg + 2'd1);
              end
            end
          end
        end

        LINE_DONE: begin
          line_done <= 1'b1;
          out_line  <= (out_line < target_height) ? out_line + LINE_W'(1) : target_height;
          state     <= IDLE;
        end

        default: begin
          state     <= IDLE;
          burst_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rd_add_man.sv
// Bench for rd_add_man: acts as line buffer and SDRAM controller, checking every
// burst and write address against a line/bank model of the frame readout.
module tb_rd_add_man;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start, line_req, line_ack, line_done, data_wen;
  logic [9:0]  data_address;
  logic        burst_req;
  logic [8:0]  burst_length;
  logic [21:0] burst_address;
  logic        burst_ack, burst_holda;
  logic [1:0]  wr_pic_number, rd_pic_number;
  logic [9:0]  target_width, target_height;

  int total = 0;
  int bad   = 0;
  int m_line = 0;
  bit m_bank = 1'b0;

  always #5 clk = ~clk;

  rd_add_man dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .line_req      (line_req),
    .line_ack      (line_ack),
    .line_done     (line_done),
    .data_wen      (data_wen),
    .data_address  (data_address),
    .burst_req     (burst_req),
    .burst_length  (burst_length),
    .burst_address (burst_address),
    .burst_ack     (burst_ack),
    .burst_holda   (burst_holda),
    .wr_pic_number (wr_pic_number),
    .rd_pic_number (rd_pic_number),
    .target_width  (target_width),
    .target_height (target_height)
  );

  task automatic do_restart(input logic [1:0] wr);
    wr_pic_number = wr;
    frame_start = 1'b1;
    repeat (4) @(negedge clk);
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    m_line = 0;
    m_bank = ~wr[1];
  endtask

  // Requests one line and plays the controller; fs_word raises frame_start at that
  // word index, abort_seg stops after five words of that segment.
  task automatic serve_line(input int tw, input int th, input int fs_word,
                            input int abort_seg, output int nb);
    int nseg, len, exp_addr, exp_pic, idx, k;
    bit skip, saw_burst;
    nb = 0; idx = 0; saw_burst = 1'b0;
    target_width  = 10'(tw);
    target_height = 10'(th);
    nseg = (tw + 255) / 256;
    skip = (m_line >= th) || (nseg == 0);
    line_req = 1'b1;
    for (int c = 0; c < 20 && line_ack !== 1'b1; c++) @(negedge clk);
    line_req = 1'b0;
    total++;
    if (line_ack !== 1'b1) begin
      bad++; $display("FAIL line_ack_timeout: got %b want 1", line_ack); return;
    end
    exp_pic = m_bank * 2 + (m_line % 2);
    total++;
    if (rd_pic_number !== 2'(exp_pic)) begin
      bad++; $display("FAIL rd_pic_at_ack: got %0d want %0d", rd_pic_number, exp_pic);
    end
    if (!skip) for (int s = 0; s < nseg; s++) begin
      for (int c = 0; c < 20 && burst_req !== 1'b1; c++) @(negedge clk);
      total++;
      if (burst_req !== 1'b1) begin
        bad++; $display("FAIL burst_req_timeout seg %0d: got %b want 1", s, burst_req); return;
      end
      nb++;
      len = (s < nseg - 1) ? 256 : tw - 256 * (nseg - 1);
      exp_addr = m_bank * (1 << 20) + (m_line % 2) * (1 << 19) + (m_line / 2) * (1 << 10) + s * 256;
      total++;
      if (burst_length !== 9'(len)) begin
        bad++; $display("FAIL burst_length seg %0d: got %0d want %0d", s, burst_length, len);
      end
      total++;
      if (burst_address !== 22'(exp_addr)) begin
        bad++; $display("FAIL burst_address seg %0d: got %h want %h", s, burst_address, exp_addr);
      end
      k = $urandom_range(0, 2);
      repeat (k) @(negedge clk);
      total++;
      if (burst_req !== 1'b1 || burst_length !== 9'(len) || burst_address !== 22'(exp_addr)) begin
        bad++; $display("FAIL burst_hold seg %0d: got req=%b len=%0d addr=%h want 1 %0d %h",
                        s, burst_req, burst_length, burst_address, len, exp_addr);
      end
      burst_ack = 1'b1;
      @(negedge clk);
      burst_ack = 1'b0;
      total++;
      if (burst_req !== 1'b0) begin
        bad++; $display("FAIL burst_req_after_ack: got %b want 0", burst_req);
      end
      for (int w = 0; w < len; w++) begin
        k = $urandom_range(0, 1);
        repeat (k) @(negedge clk);
        if (idx == fs_word) frame_start = 1'b1;
        burst_holda = 1'b1;
        #1;
        total++;
        if (data_wen !== 1'b1 || data_address !== 10'(idx)) begin
          bad++; $display("FAIL data_word: got wen=%b addr=%0d want 1 %0d", data_wen, data_address, idx);
        end
        @(negedge clk);
        burst_holda = 1'b0;
        idx++;
        if (s == abort_seg && w == 4) return;
      end
    end
    for (int c = 0; c < 20 && line_done !== 1'b1; c++) begin
      if (burst_req === 1'b1) saw_burst = 1'b1;
      @(negedge clk);
    end
    total++;
    if (line_done !== 1'b1) begin
      bad++; $display("FAIL line_done_timeout: got %b want 1", line_done); return;
    end
    if (skip) begin
      total++;
      if (saw_burst) begin
        bad++; $display("FAIL skip_no_burst: got burst_req 1 want 0");
      end
    end else begin
      total++;
      if (data_address !== 10'(tw)) begin
        bad++; $display("FAIL data_address_end: got %0d want %0d", data_address, tw);
      end
    end
    @(negedge clk);
    total++;
    if (line_done !== 1'b0 || line_ack !== 1'b0) begin
      bad++; $display("FAIL single_pulse: got done=%b ack=%b want 0 0", line_done, line_ack);
    end
    m_line = (m_line + 1 < th) ? m_line + 1 : th;
    if (fs_word >= 0) begin
      frame_start = 1'b0;
      m_line = 0;
      m_bank = ~wr_pic_number[1];
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (line_ack !== 1'b0) begin bad++; $display("FAIL rst_line_ack: got %b want 0", line_ack); end
    total++; if (line_done !== 1'b0) begin bad++; $display("FAIL rst_line_done: got %b want 0", line_done); end
    total++; if (burst_req !== 1'b0) begin bad++; $display("FAIL rst_burst_req: got %b want 0", burst_req); end
    total++; if (burst_length !== 9'h100) begin bad++; $display("FAIL rst_burst_length: got %h want 100", burst_length); end
    total++; if (burst_address !== 22'h0) begin bad++; $display("FAIL rst_burst_address: got %h want 0", burst_address); end
    total++; if (rd_pic_number !== 2'b00) begin bad++; $display("FAIL rst_rd_pic: got %b want 00", rd_pic_number); end
    total++; if (data_address !== 10'd0) begin bad++; $display("FAIL rst_data_address: got %0d want 0", data_address); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_640();
    int nb;
    do_restart(2'b00);
    serve_line(640, 4, -1, -1, nb);
    total++; if (nb !== 3) begin bad++; $display("FAIL bursts_640: got %0d want 3", nb); end
  endtask

  task automatic test_512();
    int nb;
    serve_line(512, 4, -1, -1, nb);
    total++; if (nb !== 2) begin bad++; $display("FAIL bursts_512: got %0d want 2", nb); end
  endtask

  task automatic test_field_weave();
    int nb;
    logic [1:0] exp_seq [4];
    exp_seq = '{2'b00, 2'b01, 2'b00, 2'b01};
    do_restart(2'b10);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd_pic_number !== exp_seq[i]) begin
        bad++; $display("FAIL weave_rd_pic line %0d: got %b want %b", i, rd_pic_number, exp_seq[i]);
      end
      serve_line($urandom_range(1, 600), 4, -1, -1, nb);
    end
  endtask

  task automatic test_height_skip();
    int nb;
    do_restart(2'b01);
    for (int i = 0; i < 3; i++) serve_line(300, 2, -1, -1, nb);
    total++; if (nb !== 0) begin bad++; $display("FAIL skip_bursts: got %0d want 0", nb); end
  endtask

  task automatic test_fs_mid_burst();
    int nb;
    do_restart(2'b00);
    serve_line(300, 6, -1, -1, nb);
    wr_pic_number = 2'b10;
    serve_line(300, 6, 10, -1, nb);
    total++; if (nb !== 2) begin bad++; $display("FAIL fs_mid_bursts: got %0d want 2", nb); end
    total++;
    if (rd_pic_number !== 2'b00) begin
      bad++; $display("FAIL fs_mid_restart: got %b want 00", rd_pic_number);
    end
    serve_line(200, 6, -1, -1, nb);
  endtask

  task automatic test_restart_coincide();
    int nb;
    wr_pic_number = 2'b00;
    frame_start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m_line = 0;
    m_bank = 1'b1;
    serve_line(260, 6, -1, -1, nb);
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    int nb, th, tw;
    do_restart(2'($urandom_range(0, 3)));
    th = $urandom_range(2, 6);
    for (int i = 0; i < 6; i++) begin
      tw = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 1023);
      serve_line(tw, th, -1, -1, nb);
    end
  endtask

  task automatic test_reset_mid();
    int nb;
    do_restart(2'b00);
    serve_line(100, 8, -1, -1, nb);
    serve_line(640, 8, -1, 1, nb);
    #2 rst = 1'b1;
    #1;
    total++;
    if (line_ack !== 1'b0 || line_done !== 1'b0 || burst_req !== 1'b0 ||
        burst_length !== 9'h100 || burst_address !== 22'h0 ||
        rd_pic_number !== 2'b00 || data_address !== 10'd0) begin
      bad++; $display("FAIL mid_reset_outputs: got ack=%b done=%b req=%b len=%h addr=%h pic=%b da=%0d want 0 0 0 100 0 00 0",
                      line_ack, line_done, burst_req, burst_length, burst_address, rd_pic_number, data_address);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (line_ack !== 1'b0 || line_done !== 1'b0) begin
        bad++; $display("FAIL mid_reset_pulse: got ack=%b done=%b want 0 0", line_ack, line_done);
      end
    end
    rst = 1'b0;
    m_line = 0;
    m_bank = 1'b0;
    @(negedge clk);
    serve_line(640, 8, -1, -1, nb);
    total++; if (nb !== 3) begin bad++; $display("FAIL after_reset_bursts: got %0d want 3", nb); end
  endtask

  initial begin
    rst = 1'b1;
    frame_start = 1'b0; line_req = 1'b0; burst_ack = 1'b0; burst_holda = 1'b0;
    wr_pic_number = 2'b00; target_width = 10'd0; target_height = 10'd0;
    test_reset();
    test_640();
    test_512();
    test_field_weave();
    test_height_skip();
    test_fs_mid_burst();
    test_restart_coincide();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
